// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 16x16 shift-add multiplier sequencer that borrows the shared
// 16-bit adder (add_a/add_b/add_cin out, add_sum/add_cout back in the same
// cycle) instead of owning a multiplier array.
// Optional signed support is compiled in with `define MUL_SIGNED_EN.
//
//   state  | meaning
//   IDLE   | waiting for start, adder inputs held at zero
//   ABS_A  | (signed) replace multiplicand by its magnitude
//   ABS_B  | (signed) replace multiplier by its magnitude
//   RUN    | one shift-add iteration per cycle, 16 cycles
//   NEG_LO | (signed) two's-complement low product half, keep carry
//   NEG_HI | (signed) two's-complement high product half using that carry
//   DONE   | one-cycle done pulse, product valid
module mul_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DONE
`ifdef MUL_SIGNED_EN
    , S_ABS_A
    , S_ABS_B
    , S_NEG_LO
    , S_NEG_HI
`endif
  } state_t;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    hi, hi_nxt;
  logic [WIDTH-1:0]    lo, lo_nxt;
  logic [WIDTH-1:0]    mcand, mcand_nxt;
  logic [ITER_W-1:0]   count, count_nxt;

`ifdef MUL_SIGNED_EN
  logic neg, neg_nxt;
  logic carry, carry_nxt;
`else
  // is_signed has no meaning without the signed datapath
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
`endif

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  // Next-state, adder operand steering and datapath update
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    lo_nxt    = lo;
    mcand_nxt = mcand;
    count_nxt = count;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
`ifdef MUL_SIGNED_EN
    neg_nxt   = neg;
    carry_nxt = carry;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          hi_nxt    = '0;
          lo_nxt    = op_b;
          mcand_nxt = op_a;
          count_nxt = '0;
`ifdef MUL_SIGNED_EN
          neg_nxt   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          state_nxt = is_signed ? S_ABS_A : S_RUN;
`else
          state_nxt = S_RUN;
`endif
        end
      end
      S_RUN: begin
        add_a     = hi;
        add_b     = lo[0] ? mcand : '0;
        hi_nxt    = {add_cout, add_sum[WIDTH-1:1]};
        lo_nxt    = {add_sum[0], lo[WIDTH-1:1]};
        count_nxt = count + 1'b1;
        if (count == LAST_ITER) begin
`ifdef MUL_SIGNED_EN
          state_nxt = neg ? S_NEG_LO : S_DONE;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
`ifdef MUL_SIGNED_EN
      // -32768 maps to 0x8000, which the unsigned core reads as +32768
      S_ABS_A: begin
        if (mcand[WIDTH-1]) begin
          add_a     = ~mcand;
          add_cin   = 1'b1;
          mcand_nxt = add_sum;
        end
        state_nxt = S_ABS_B;
      end
      S_ABS_B: begin
        if (lo[WIDTH-1]) begin
          add_a   = ~lo;
          add_cin = 1'b1;
          lo_nxt  = add_sum;
        end
        state_nxt = S_RUN;
      end
      S_NEG_LO: begin
        add_a     = ~lo;
        add_cin   = 1'b1;
        lo_nxt    = add_sum;
        carry_nxt = add_cout;
        state_nxt = S_NEG_HI;
      end
      S_NEG_HI: begin
        add_a     = ~hi;
        add_cin   = carry;
        hi_nxt    = add_sum;
        state_nxt = S_DONE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; product loads on the edge entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
`ifdef MUL_SIGNED_EN
      neg     <= 1'b0;
      carry   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      mcand <= mcand_nxt;
      count <= count_nxt;
`ifdef MUL_SIGNED_EN
      neg   <= neg_nxt;
      carry <= carry_nxt;
`endif
      if (state_nxt == S_DONE) begin
        product <= {hi_nxt, lo_nxt};
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a behavioural adder and an
// arithmetic reference model (product and latency from operand values).
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        is_signed = 1'b0;
  logic        busy, done;
  logic [31:0] product;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] held_prod = '0;

  always #5 clk = ~clk;

  // Shared adder stand-in
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  mul_seq_ctrl #(.WIDTH(16), .ITER_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] sa, sb;
    sa = $signed({{16{a[15]}}, a});
    sb = $signed({{16{b[15]}}, b});
`ifdef MUL_SIGNED_EN
    if (s) return sa * sb;
`endif
    return {16'h0, a} * {16'h0, b};
  endfunction

  // Edges from the start-sampling edge (counted as 1) until done is visible
  function automatic int model_lat(input logic [15:0] a, input logic [15:0] b, input logic s);
`ifdef MUL_SIGNED_EN
    if (s) return 19 + ((a[15] ^ b[15]) ? 2 : 0);
`endif
    return 17;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int poke, input string tag);
    logic [31:0] ep;
    int el, lat, nbusy;
    ep = model_prod(a, b, s);
    el = model_lat(a, b, s);
    @(negedge clk);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    chk({tag, " held"}, product, held_prod);
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      start = (lat == poke);
      if (lat == poke) begin
        op_a = 16'h0007; op_b = 16'h0007;
      end else begin
        op_a = 16'($urandom); op_b = 16'($urandom);
      end
      is_signed = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " product"}, product, ep);
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'(el - 1));
    chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    held_prod = ep;
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, " product_hold"}, product, ep);
    chk({tag, " idle_add_a"}, {16'b0, add_a}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst product", product, 32'd0);
      chk("rst add_ab", {add_a, add_b}, 32'd0);
    end

    run_op(16'h1234, 16'h0010, 1'b0, 0, "basic");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, "allones");
    run_op(16'h0002, 16'h0003, 1'b0, 5, "start_busy");
    run_op(16'h0007, 16'h0007, 1'b0, 0, "after_ignored");
    run_op(16'h0000, 16'hBEEF, 1'b0, 0, "zero");

    // Abort in the middle of RUN
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h5678; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort product", product, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    held_prod = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort no_done", {31'b0, done}, 32'd0);
    end
    run_op(16'h0003, 16'h0005, 1'b0, 0, "post_abort");

    run_op(16'hFFFD, 16'h0005, 1'b1, 0, "signed_m3x5");
    run_op(16'h8000, 16'h8000, 1'b1, 0, "signed_min_min");
    run_op(16'h8000, 16'h0001, 1'b1, 0, "signed_min_one");
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, "signed_neg_zero");

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'h8000;
        1: ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
